dense_layer_2: RTL and testbench

Second fully-connected layer of the speech-recognition network. It sits directly downstream of the layer-1 dropout stage and consumes that stage's OUT_SIZE_1 vector of signed 28-bit activations. It computes OUT_SIZE_2 neuron outputs sequentially with one multiply-accumulate per cycle, reading weights and biases from an external synchronous ROM. It presents the results as a registered vector together with a one-cycle done pulse.

---
 rtl/dense_layer_2.sv | 157 +++++++++++++++
 tb/tb_dense_layer_2.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dense_layer_2.sv
// rtl/dense_layer_2.sv - second fully-connected layer, one MAC per cycle against a synchronous weight/bias ROM
module dense_layer_2 #(
    parameter int IN_SIZE  = 64,
    parameter int OUT_SIZE = 10,
    parameter int DATA_W   = 28,
    parameter int W_W      = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 48,
    localparam int ADDR_W  = $clog2(OUT_SIZE*IN_SIZE+OUT_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [IN_SIZE-1:0][DATA_W-1:0]    input_vector,
    output logic [ADDR_W-1:0]                 w_addr,
    input  logic signed [W_W-1:0]             w_data,
    output logic [OUT_SIZE-1:0][DATA_W-1:0]   output_vector,
    output logic                              busy,
    output logic                              done
);
    localparam int I_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int J_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [I_W-1:0] LAST_I = I_W'(IN_SIZE-1);
    localparam logic [J_W-1:0] LAST_J = J_W'(OUT_SIZE-1);
    localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(OUT_SIZE*IN_SIZE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MAC, S_BIAS, S_DRAIN, S_STORE, S_DONE} state_t;

    state_t                             state_q, state_d;
    logic [IN_SIZE-1:0][DATA_W-1:0]     x_q, x_d;
    logic signed [ACC_W-1:0]            acc_q, acc_d;
    logic [I_W-1:0]                     i_q, i_d;
    logic [J_W-1:0]                     j_q, j_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic [OUT_SIZE-1:0][DATA_W-1:0]    stage_q, stage_d;
    logic [OUT_SIZE-1:0][DATA_W-1:0]    out_q, out_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    // ROM data lags the address by one cycle, so the activation paired with
    // w_data is the one addressed in the previous cycle.
    logic signed [DATA_W-1:0]           mac_x;
    logic signed [DATA_W+W_W-1:0]       prod;
    logic signed [ACC_W-1:0]            prod_ext;
    logic signed [ACC_W-1:0]            bias_ext;
    logic signed [ACC_W-1:0]            shifted;
    logic [DATA_W-1:0]                  sat_res;

    assign mac_x    = (state_q == S_BIAS) ? x_q[IN_SIZE-1] : x_q[i_q - I_W'(1)];
    assign prod     = mac_x * w_data;
    assign prod_ext = {{(ACC_W-DATA_W-W_W){prod[DATA_W+W_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-W_W){w_data[W_W-1]}}, w_data};
    assign shifted  = acc_q >>> FRAC;

    always_comb begin
        if (shifted > SAT_MAX)      sat_res = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) sat_res = SAT_MIN[DATA_W-1:0];
        else                        sat_res = shifted[DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = input_vector;
                    busy_d  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                acc_d   = '0;
                j_d     = '0;
                i_d     = '0;
                addr_d  = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (i_q != '0) acc_d = acc_q + prod_ext;
                if (i_q == LAST_I) begin
                    addr_d  = BIAS_BASE + ADDR_W'(j_q);
                    state_d = S_BIAS;
                end else begin
                    i_d    = i_q + I_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_BIAS: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_STORE;
            end
            S_STORE: begin
                stage_d[j_q] = sat_res;
                acc_d        = '0;
                if (j_q != LAST_J) begin
                    j_d     = j_q + J_W'(1);
                    i_d     = '0;
                    addr_d  = ADDR_W'((int'(j_q) + 1) * IN_SIZE);
                    state_d = S_MAC;
                end else begin
                    out_d   = stage_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            stage_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w_addr        = addr_q;
    assign output_vector = out_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_dense_layer_2.sv
// tb/tb_dense_layer_2.sv - directed vector bench for dense_layer_2 (IN_SIZE=4, OUT_SIZE=2)
module tb_dense_layer_2;
    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam int DW  = 28;
    localparam int WW  = 16;
    localparam int AW  = $clog2(OUT*IN+OUT);
    localparam int NV  = 7;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [IN-1:0][DW-1:0]     input_vector;
    logic [AW-1:0]             w_addr;
    logic signed [WW-1:0]      w_data;
    logic [OUT-1:0][DW-1:0]    output_vector;
    logic                      busy;
    logic                      done;

    dense_layer_2 #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .W_W(WW), .FRAC(8), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .start(start), .input_vector(input_vector),
        .w_addr(w_addr), .w_data(w_data), .output_vector(output_vector),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic signed [WW-1:0] rom [OUT*IN+OUT];
    always @(posedge clk) w_data <= (int'(w_addr) < OUT*IN+OUT) ? rom[w_addr] : '0;

    typedef struct {
        int x[IN];
        int w[OUT*IN];
        int b[OUT];
        int e[OUT];
    } vec_t;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int k);
        for (int i = 0; i < OUT*IN; i++) rom[i] = WW'(vecs[k].w[i]);
        for (int j = 0; j < OUT; j++) rom[OUT*IN+j] = WW'(vecs[k].b[j]);
        for (int i = 0; i < IN; i++) input_vector[i] = DW'(vecs[k].x[i]);
    endtask

    task automatic run_vec(input int k);
        int cyc;
        int busy_cnt;
        load(k);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
        end
        check($sformatf("v%0d latency", k), cyc, 16);
        check($sformatf("v%0d busy_cycles", k), busy_cnt, 15);
        for (int j = 0; j < OUT; j++)
            check($sformatf("v%0d out[%0d]", k, j), $signed(output_vector[j]), vecs[k].e[j]);
        @(negedge clk);
        check($sformatf("v%0d done_one_cycle", k), done, 0);
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_seen;

        vecs[0].x = '{256, 256, 256, 256};
        vecs[0].w = '{256, 256, 256, 256, 256, 256, 256, 256};
        vecs[0].b = '{0, 0};
        vecs[0].e = '{1024, 1024};
        vecs[1].x = '{100, -200, 300, -400};
        vecs[1].w = '{256, 256, 256, 256, -256, 0, 0, 0};
        vecs[1].b = '{512, 0};
        vecs[1].e = '{-198, -100};
        vecs[2].x = '{134217727, 134217727, 134217727, 134217727};
        vecs[2].w = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        vecs[2].b = '{0, 0};
        vecs[2].e = '{134217727, 134217727};
        vecs[3].x = '{134217727, 134217727, 134217727, 134217727};
        vecs[3].w = '{-32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767};
        vecs[3].b = '{0, 0};
        vecs[3].e = '{-134217728, -134217728};
        vecs[4].x = '{-1, 0, 0, 0};
        vecs[4].w = '{1, 0, 0, 0, 1, 0, 0, 0};
        vecs[4].b = '{0, 0};
        vecs[4].e = '{-1, -1};
        vecs[5].x = '{1, 0, 0, 0};
        vecs[5].w = '{1, 0, 0, 0, 1, 0, 0, 0};
        vecs[5].b = '{0, 0};
        vecs[5].e = '{0, 0};
        vecs[6].x = '{0, 0, 0, 0};
        vecs[6].w = '{7, 7, 7, 7, 7, 7, 7, 7};
        vecs[6].b = '{-256, 255};
        vecs[6].e = '{-1, 0};

        rst = 1'b1;
        start = 1'b0;
        input_vector = '0;
        for (int i = 0; i < OUT*IN+OUT; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset w_addr", w_addr, 0);
        check("reset out0", $signed(output_vector[0]), 0);
        check("reset out1", $signed(output_vector[1]), 0);

        for (int k = 0; k < NV; k++) run_vec(k);

        // start held high; input changes one cycle after it is sampled
        load(0);
        @(negedge clk) start = 1'b1;
        first_done = 0;
        second_done = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) for (int i = 0; i < IN; i++) input_vector[i] = DW'(512);
            if (done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    check("hold run1 out0", $signed(output_vector[0]), 1024);
                    check("hold run1 out1", $signed(output_vector[1]), 1024);
                end else begin
                    second_done = cyc;
                    start = 1'b0;
                    check("hold run2 out0", $signed(output_vector[0]), 2048);
                    check("hold run2 out1", $signed(output_vector[1]), 2048);
                    break;
                end
            end
        end
        start = 1'b0;
        check("hold first done", first_done, 16);
        check("hold done period", second_done - first_done, 17);
        @(negedge clk);

        // reset mid-run at cycle 8
        load(1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun out0 held", $signed(output_vector[0]), 2048);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst out0", $signed(output_vector[0]), 0);
        check("midrst out1", $signed(output_vector[1]), 0);
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst no done", done_seen, 0);
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
